ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM pipeline register of the 16-bit pipelined core, downstream of the EX-stage result mux that selects among ALU, RED_16b, PADDSB and shifter outputs. It captures the EX result and control bits for the MEM stage, and owns the N/V/Z flag register with per-opcode update rules. It resolves branch conditions against the flags, forwarding flags from the instruction currently in EX, and latches the sticky halt indication.

## Interface
Parameters:
- none (widths fixed by ISA: 16-bit data, 4-bit opcode/register index, 3-bit condition)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  EX holds a real instruction
- stall  in  1  hold EX/MEM contents and flags
- flush  in  1  replace the instruction leaving EX with a bubble
- ex_opcode  in  4  opcode of the EX instruction
- ex_result  in  16  muxed EX result (ALU/RED/PADDSB/shift/LHB/LLB/PCS/address)
- ex_ovfl  in  1  signed overflow from the ADD/SUB adder
- ex_rd  in  4  destination register
- ex_regwrite, ex_memread, ex_memwrite  in  1 each  control bits
- ex_store_data  in  16  SW data
- br_check  in  1  ID holds B or BR
- br_cond  in  3  condition field of that branch
- mem_valid, mem_regwrite, mem_memread, mem_memwrite  out  1 each  registered controls
- mem_result, mem_store_data  out  16  registered data
- mem_rd  out  4  registered destination
- flag_n, flag_v, flag_z  out  1 each  architectural flags
- br_taken  out  1  combinational branch decision
- halted  out  1  sticky, set when HLT enters MEM

## Operation
- Opcodes: ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, LW 1000, SW 1001, LHB 1010, LLB 1011, B 1100, BR 1101, PCS 1110, HLT 1111.
- Advance condition: adv = !stall. When adv is set, the pipeline register loads EX inputs, or a bubble if flush || !ex_valid.
- Bubble: mem_valid=0; regwrite, memread and memwrite=0; data and rd fields hold their previous values.
- Flag update happens only on adv && ex_valid && !flush:
  - ADD/SUB: Z=(ex_result==0), N=ex_result[15], V=ex_ovfl.
  - XOR/SLL/SRA/ROR: Z only.
  - All other opcodes, including RED and PADDSB: flags unchanged.
- Forwarded flags (fN,fV,fZ) are the values the flags will take at the next edge if an update occurs this cycle. Otherwise they are the stored flags.
- br_taken = br_check && cond(fN,fV,fZ), where cond is:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z&&!N
  - 011 LT: N
  - 100 GTE: Z||(!Z&&!N)
  - 101 LTE: N||Z
  - 110 OV: V
  - 111 always
- halted is set when a valid, non-flushed HLT is loaded. It clears only on reset. Later loads continue normally; the fetch side gates on halted.

## Timing
- Reset (rst_n=0 at an edge): all mem_* outputs are 0, flags are 000, and halted is 0. Reset overrides stall and flush.
- Pipeline latency: 1 cycle from EX inputs to mem_* outputs.
- Flags become visible at the edge after the update.
- br_taken has zero latency and reflects forwarded flags in the same cycle.
- Stall and flush asserted together: stall wins, so everything is held and no flag update occurs. The flush must be reasserted once stall drops.
- Stall lasting N cycles: outputs are held for exactly N cycles, with no duplicate flag update.
- Reset arriving mid-stall clears all state on that edge.

## Structure
- Shared package `wisc_pkg`:
  - opcode localparams
  - condition-code localparams
  - `FLAG_*` bit indices
- Sub-module `flag_unit`: flag-next logic, the flag register and condition evaluation, with outputs flags and br_taken.
- Top level: the EX/MEM register, bubble insertion and the halt latch.

## Test plan
- Reset: drive rst_n=0 with random inputs. Required: all outputs 0 and br_taken=0 for br_check=0.
- ADD producing 0x0000 with ovfl=0, then a B with cond 001 in the same cycle. Required: br_taken=1 (forwarded); next cycle Z=1, N=0, V=0 and mem_result=0x0000.
- RED producing 0xfff8 after flags have been set to Z=1. Required: mem_result=0xfff8 next cycle and flags still Z=1, N=0, V=0.
- SUB producing 0x8000 with ovfl=1, followed by XOR producing 0x0024. Required: after the SUB, N=1, V=1, Z=0; after the XOR, Z=0 with N=1 and V=1 retained; cond 110 gives br_taken=1.
- Stall for 3 cycles with an ADD in EX, and flush asserted during the stall. Required: outputs held, flags unchanged, and a single update once stall drops.
- Flushed HLT, then a valid HLT. Required: halted stays 0 after the flushed HLT and becomes 1 one cycle after the valid HLT, remaining set until rst_n=0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared ISA definitions for the 16-bit pipelined core: opcodes, branch
// condition codes, flag bit positions and the branch condition evaluator.
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LHB    = 4'b1010;
   localparam logic [3:0] OP_LLB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   localparam logic [2:0] COND_NE  = 3'b000;
   localparam logic [2:0] COND_EQ  = 3'b001;
   localparam logic [2:0] COND_GT  = 3'b010;
   localparam logic [2:0] COND_LT  = 3'b011;
   localparam logic [2:0] COND_GTE = 3'b100;
   localparam logic [2:0] COND_LTE = 3'b101;
   localparam logic [2:0] COND_OV  = 3'b110;
   localparam logic [2:0] COND_UNC = 3'b111;

   // Flags are carried as a 3-bit vector {N, V, Z}
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   // Evaluates a branch condition code against a {N, V, Z} flag vector
   function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] flags);
      logic n;
      logic v;
      logic z;
      logic res;
      n = flags[FLAG_N];
      v = flags[FLAG_V];
      z = flags[FLAG_Z];
      res = 1'b0;
      case (cond)
         COND_NE:  res = !z;
         COND_EQ:  res = z;
         COND_GT:  res = !z && !n;
         COND_LT:  res = n;
         COND_GTE: res = z || (!z && !n);
         COND_LTE: res = n || z;
         COND_OV:  res = v;
         COND_UNC: res = 1'b1;
         default:  res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM bus: the EX stage drives the instruction leaving EX, the
// EX/MEM register presents the registered copy to the MEM stage.
interface ex_mem_stage_if;
   import wisc_pkg::*;

   logic        ex_valid;
   logic [3:0]  ex_opcode;
   logic [15:0] ex_result;
   logic        ex_ovfl;
   logic [3:0]  ex_rd;
   logic        ex_regwrite;
   logic        ex_memread;
   logic        ex_memwrite;
   logic [15:0] ex_store_data;

   logic        mem_valid;
   logic        mem_regwrite;
   logic        mem_memread;
   logic        mem_memwrite;
   logic [15:0] mem_result;
   logic [15:0] mem_store_data;
   logic [3:0]  mem_rd;

   modport master (
      output ex_valid, ex_opcode, ex_result, ex_ovfl, ex_rd,
             ex_regwrite, ex_memread, ex_memwrite, ex_store_data,
      input  mem_valid, mem_regwrite, mem_memread, mem_memwrite,
             mem_result, mem_store_data, mem_rd
   );

   modport slave (
      input  ex_valid, ex_opcode, ex_result, ex_ovfl, ex_rd,
             ex_regwrite, ex_memread, ex_memwrite, ex_store_data,
      output mem_valid, mem_regwrite, mem_memread, mem_memwrite,
             mem_result, mem_store_data, mem_rd
   );

endinterface

// File: rtl/ex_mem_stage_flag_unit.sv
// N/V/Z flag register with per-opcode update rules. The branch decision
// uses the flag values that will be stored at the next edge, so a branch
// in ID sees the effect of the instruction currently in EX.
module flag_unit
   import wisc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        update_en,
   input  logic [3:0]  opcode,
   input  logic [15:0] result,
   input  logic        ovfl,
   input  logic        br_check,
   input  logic [2:0]  br_cond,
   output logic        flag_n,
   output logic        flag_v,
   output logic        flag_z,
   output logic        br_taken
);

   logic [2:0] flags_q;
   logic [2:0] flags_next;

   // Next-flag value; defaults to holding so stalls and bubbles never update
   always_comb begin
      flags_next = flags_q;
      if (update_en) begin
         case (opcode)
            OP_ADD, OP_SUB: begin
               flags_next[FLAG_Z] = (result == 16'h0000);
               flags_next[FLAG_N] = result[15];
               flags_next[FLAG_V] = ovfl;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
               flags_next[FLAG_Z] = (result == 16'h0000);
            end
            default: flags_next = flags_q;
         endcase
      end
   end

   // Flag register; reset clears all three flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= 3'b000;
      end else begin
         flags_q <= flags_next;
      end
   end

   // Branch decision against the forwarded flags, zero latency
   always_comb begin
      br_taken = br_check && cond_met(br_cond, flags_next);
   end

   assign flag_n = flags_q[FLAG_N];
   assign flag_v = flags_q[FLAG_V];
   assign flag_z = flags_q[FLAG_Z];

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the EX result and control bits for
// MEM, inserts bubbles on flush or empty EX, owns the flag unit and keeps
// the sticky halt indication.
module ex_mem_stage
   import wisc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   ex_mem_stage_if.slave        bus,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 br_check,
   input  logic [2:0]           br_cond,
   output logic                 flag_n,
   output logic                 flag_v,
   output logic                 flag_z,
   output logic                 br_taken,
   output logic                 halted
);

   logic adv;
   logic load;

   // Stall wins over flush: nothing moves and no flag update happens
   always_comb begin
      adv  = !stall;
      load = adv && bus.ex_valid && !flush;
   end

   // Pipeline register; a bubble clears valid and controls but keeps data/rd
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.mem_valid      <= 1'b0;
         bus.mem_regwrite   <= 1'b0;
         bus.mem_memread    <= 1'b0;
         bus.mem_memwrite   <= 1'b0;
         bus.mem_result     <= 16'h0000;
         bus.mem_store_data <= 16'h0000;
         bus.mem_rd         <= 4'h0;
      end else if (adv) begin
         bus.mem_valid    <= load;
         bus.mem_regwrite <= load && bus.ex_regwrite;
         bus.mem_memread  <= load && bus.ex_memread;
         bus.mem_memwrite <= load && bus.ex_memwrite;
         if (load) begin
            bus.mem_result     <= bus.ex_result;
            bus.mem_store_data <= bus.ex_store_data;
            bus.mem_rd         <= bus.ex_rd;
         end
      end
   end

   // Halt latch; only reset clears it, fetch gates on it downstream
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         halted <= 1'b0;
      end else if (load && (bus.ex_opcode == OP_HLT)) begin
         halted <= 1'b1;
      end
   end

   flag_unit u_flag_unit (
      .clk       (clk),
      .rst_n     (rst_n),
      .update_en (load),
      .opcode    (bus.ex_opcode),
      .result    (bus.ex_result),
      .ovfl      (bus.ex_ovfl),
      .br_check  (br_check),
      .br_cond   (br_cond),
      .flag_n    (flag_n),
      .flag_v    (flag_v),
      .flag_z    (flag_z),
      .br_taken  (br_taken)
   );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the EX/MEM register and flags.
module tb_ex_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        br_check;
   logic [2:0]  br_cond;
   logic        flag_n;
   logic        flag_v;
   logic        flag_z;
   logic        br_taken;
   logic        halted;

   ex_mem_stage_if bus ();

   ex_mem_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .stall    (stall),
      .flush    (flush),
      .br_check (br_check),
      .br_cond  (br_cond),
      .flag_n   (flag_n),
      .flag_v   (flag_v),
      .flag_z   (flag_z),
      .br_taken (br_taken),
      .halted   (halted)
   );

   int total_checks  = 0;
   int passed_checks = 0;

   // Reference state
   logic        m_valid, m_rw, m_mr, m_mw;
   logic [15:0] m_result, m_sd;
   logic [3:0]  m_rd;
   logic        m_n, m_v, m_z;
   logic        m_halt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_checks++;
      assert (obs === exp) begin
         passed_checks++;
      end else begin
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // True when the instruction in EX is really written into MEM this cycle
   function automatic logic model_loads();
      return !stall && bus.ex_valid && !flush;
   endfunction

   // Flags {N,V,Z} that the instruction in EX would leave behind
   function automatic logic [2:0] model_fwd_flags();
      logic [2:0] f;
      int op;
      f  = {m_n, m_v, m_z};
      op = int'(bus.ex_opcode);
      if (model_loads()) begin
         if (op == 0 || op == 1)
            f = {bus.ex_result[15], bus.ex_ovfl, bus.ex_result == 16'd0};
         else if (op == 2 || op == 4 || op == 5 || op == 6)
            f[0] = (bus.ex_result == 16'd0);
      end
      return f;
   endfunction

   function automatic logic model_branch();
      logic [2:0] f;
      logic n, v, z, t;
      f = model_fwd_flags();
      n = f[2]; v = f[1]; z = f[0];
      case (br_cond)
         3'd0: t = !z;
         3'd1: t = z;
         3'd2: t = !z && !n;
         3'd3: t = n;
         3'd4: t = z || !n;
         3'd5: t = n || z;
         3'd6: t = v;
         default: t = 1'b1;
      endcase
      return br_check && t;
   endfunction

   task automatic model_edge();
      logic [2:0] f;
      logic ld;
      f  = model_fwd_flags();
      ld = model_loads();
      if (!rst_n) begin
         {m_valid, m_rw, m_mr, m_mw} = 4'b0;
         m_result = 16'd0; m_sd = 16'd0; m_rd = 4'd0;
         {m_n, m_v, m_z} = 3'b0;
         m_halt = 1'b0;
      end else if (!stall) begin
         m_valid = ld;
         m_rw = ld && bus.ex_regwrite;
         m_mr = ld && bus.ex_memread;
         m_mw = ld && bus.ex_memwrite;
         if (ld) begin
            m_result = bus.ex_result;
            m_sd     = bus.ex_store_data;
            m_rd     = bus.ex_rd;
            if (bus.ex_opcode == 4'hF) m_halt = 1'b1;
         end
         {m_n, m_v, m_z} = f;
      end
   endtask

   task automatic apply_stimulus(input logic valid, input logic [3:0] op, input logic [15:0] res,
                                 input logic ovfl, input logic st, input logic fl);
      bus.ex_valid      = valid;
      bus.ex_opcode     = op;
      bus.ex_result     = res;
      bus.ex_ovfl       = ovfl;
      bus.ex_rd         = 4'($urandom);
      bus.ex_regwrite   = 1'($urandom);
      bus.ex_memread    = 1'($urandom);
      bus.ex_memwrite   = 1'($urandom);
      bus.ex_store_data = 16'($urandom);
      stall = st;
      flush = fl;
   endtask

   // One cycle: check the combinational branch, clock, then check registers
   task automatic step();
      #1;
      check_output("br_taken", {15'd0, br_taken}, {15'd0, model_branch()});
      @(posedge clk);
      model_edge();
      #1;
      check_output("mem_valid",      {15'd0, bus.mem_valid},    {15'd0, m_valid});
      check_output("mem_regwrite",   {15'd0, bus.mem_regwrite}, {15'd0, m_rw});
      check_output("mem_memread",    {15'd0, bus.mem_memread},  {15'd0, m_mr});
      check_output("mem_memwrite",   {15'd0, bus.mem_memwrite}, {15'd0, m_mw});
      check_output("mem_result",     bus.mem_result,            m_result);
      check_output("mem_store_data", bus.mem_store_data,        m_sd);
      check_output("mem_rd",         {12'd0, bus.mem_rd},       {12'd0, m_rd});
      check_output("flags_nvz",      {13'd0, flag_n, flag_v, flag_z}, {13'd0, m_n, m_v, m_z});
      check_output("halted",         {15'd0, halted},           {15'd0, m_halt});
   endtask

   initial begin
      {m_valid, m_rw, m_mr, m_mw, m_n, m_v, m_z, m_halt} = 8'b0;
      m_result = 16'd0; m_sd = 16'd0; m_rd = 4'd0;
      br_check = 1'b0;
      br_cond  = 3'd0;

      // Reset with random inputs
      rst_n = 1'b0;
      apply_stimulus(1'b1, 4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      step();
      check_output("reset_flags", {13'd0, flag_n, flag_v, flag_z}, 16'd0);
      check_output("reset_valid", {15'd0, bus.mem_valid}, 16'd0);
      check_output("reset_result", bus.mem_result, 16'd0);

      // ADD -> 0 with a BEQ in ID the same cycle
      rst_n = 1'b1;
      apply_stimulus(1'b1, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
      br_check = 1'b1; br_cond = 3'b001;
      #1 check_output("add_beq_fwd", {15'd0, br_taken}, 16'd1);
      step();
      check_output("add_flags", {13'd0, flag_n, flag_v, flag_z}, 16'b001);
      check_output("add_result", bus.mem_result, 16'h0000);
      br_check = 1'b0;

      // RED leaves flags alone
      apply_stimulus(1'b1, 4'h3, 16'hfff8, 1'b1, 1'b0, 1'b0);
      step();
      check_output("red_result", bus.mem_result, 16'hfff8);
      check_output("red_flags", {13'd0, flag_n, flag_v, flag_z}, 16'b001);

      // SUB -> 0x8000 with overflow, then XOR with an OV branch
      apply_stimulus(1'b1, 4'h1, 16'h8000, 1'b1, 1'b0, 1'b0);
      step();
      check_output("sub_flags", {13'd0, flag_n, flag_v, flag_z}, 16'b110);
      apply_stimulus(1'b1, 4'h2, 16'h0024, 1'b0, 1'b0, 1'b0);
      br_check = 1'b1; br_cond = 3'b110;
      #1 check_output("xor_bov_fwd", {15'd0, br_taken}, 16'd1);
      step();
      check_output("xor_flags", {13'd0, flag_n, flag_v, flag_z}, 16'b110);
      br_check = 1'b0;

      // ADD -> 0 held by a 3-cycle stall with flush asserted throughout
      apply_stimulus(1'b1, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b1);
      br_check = 1'b1; br_cond = 3'b001;
      for (int i = 0; i < 3; i++) begin
         step();
         check_output("stall_held_result", bus.mem_result, 16'h0024);
         check_output("stall_held_flags", {13'd0, flag_n, flag_v, flag_z}, 16'b110);
      end
      stall = 1'b0; flush = 1'b0;
      step();
      check_output("post_stall_flags", {13'd0, flag_n, flag_v, flag_z}, 16'b001);
      bus.ex_valid = 1'b0;
      step();
      check_output("bubble_valid", {15'd0, bus.mem_valid}, 16'd0);
      br_check = 1'b0;

      // Flushed HLT, then a real HLT
      apply_stimulus(1'b1, 4'hF, 16'h1234, 1'b0, 1'b0, 1'b1);
      step();
      check_output("flushed_hlt", {15'd0, halted}, 16'd0);
      apply_stimulus(1'b1, 4'hF, 16'h1234, 1'b0, 1'b0, 1'b0);
      step();
      check_output("valid_hlt", {15'd0, halted}, 16'd1);
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         step();
      end
      check_output("hlt_sticky", {15'd0, halted}, 16'd1);

      // Reset in the middle of a stall
      apply_stimulus(1'b1, 4'h0, 16'h8000, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      step();
      check_output("reset_midstall_halt", {15'd0, halted}, 16'd0);
      rst_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         apply_stimulus($urandom_range(0, 3) != 0, 4'($urandom), 
                        ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                        1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
         br_check = 1'($urandom);
         br_cond  = 3'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
